// File: rtl/exec_pkg.sv
// Shared types and sizing for the SIMD execute stage.
package exec_pkg;

    localparam int unsigned VEC_SIZE = 4;
    localparam int unsigned REG_SIZE = 16;
    localparam int unsigned SHAMT_W  = $clog2(REG_SIZE);
    localparam int unsigned LANE_W   = $clog2(VEC_SIZE);
    localparam int unsigned OP_W     = 4;

    typedef enum logic [OP_W-1:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_AND   = 4'd2,
        OP_OR    = 4'd3,
        OP_XOR   = 4'd4,
        OP_SLL   = 4'd5,
        OP_SRL   = 4'd6,
        OP_PASSB = 4'd7,
        OP_MUL   = 4'd8
    } alu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } exec_state_e;

    typedef logic [VEC_SIZE-1:0][REG_SIZE-1:0] vec_t;

    // Memory/writeback controls carried alongside the result
    typedef struct packed {
        logic       writeEnable;
        logic       writeMemFrom;
        logic [1:0] writeRegFrom;
    } wb_ctrl_t;

endpackage

// File: rtl/vector_lane_alu.sv
// Combinational single-lane ALU for all single-cycle ops; MUL and undefined opcodes yield 0.
module vector_lane_alu
    import exec_pkg::*;
(
    input  alu_op_e              op,
    input  logic [REG_SIZE-1:0]  a,
    input  logic [REG_SIZE-1:0]  b,
    input  logic [SHAMT_W-1:0]   shamt,
    output logic [REG_SIZE-1:0]  result
);

    always_comb begin
        result = '0;
        case (op)
            OP_ADD:   result = a + b;
            OP_SUB:   result = a - b;
            OP_AND:   result = a & b;
            OP_OR:    result = a | b;
            OP_XOR:   result = a ^ b;
            OP_SLL:   result = a << shamt;
            OP_SRL:   result = a >> shamt;
            OP_PASSB: result = b;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// Vector execute stage: lane-parallel single-cycle ALU plus an iterative
// one-lane-per-cycle multiplier, feeding a registered output bank.
module execute_stage
    import exec_pkg::*;
(
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               valid_in,
    output logic                               ready_out,
    input  logic                               flush,
    input  logic [OP_W-1:0]                    op,
    input  logic [VEC_SIZE-1:0][REG_SIZE-1:0]  srcA,
    input  logic [VEC_SIZE-1:0][REG_SIZE-1:0]  srcB,
    input  logic [REG_SIZE-1:0]                imm_in,
    input  logic                               writeEnable_in,
    input  logic                               writeMemFrom_in,
    input  logic [1:0]                         writeRegFrom_in,
    output logic                               valid_out,
    output logic [VEC_SIZE-1:0][REG_SIZE-1:0]  aluResult,
    output logic [VEC_SIZE-1:0][REG_SIZE-1:0]  aluOperand1,
    output logic [VEC_SIZE-1:0][REG_SIZE-1:0]  aluOperand2,
    output logic [REG_SIZE-1:0]                imm,
    output logic                               writeEnable,
    output logic                               writeMemFrom,
    output logic [1:0]                         writeRegFrom
);

    exec_state_e          state, stateNext;
    logic [LANE_W-1:0]    laneCnt, laneCntNext;
    logic                 latchMul, loadAlu, loadMul;

    vec_t                 laneOut;
    vec_t                 mulA, mulB, mulBuf, mulVec;
    logic [REG_SIZE-1:0]  mulImm;
    logic [REG_SIZE-1:0]  mulLane;
    wb_ctrl_t             mulCtrl, ctrlIn, wbCtrl;

    assign ctrlIn    = '{writeEnable: writeEnable_in, writeMemFrom: writeMemFrom_in,
                         writeRegFrom: writeRegFrom_in};
    assign ready_out = (state == ST_IDLE);

    for (genvar i = 0; i < VEC_SIZE; i++) begin : gLane
        vector_lane_alu uLaneAlu (
            .op     (alu_op_e'(op)),
            .a      (srcA[i]),
            .b      (srcB[i]),
            .shamt  (imm_in[SHAMT_W-1:0]),
            .result (laneOut[i])
        );
    end

    // Shared multiplier; only the low REG_SIZE bits of the product are kept
    assign mulLane = REG_SIZE'(mulA[laneCnt] * mulB[laneCnt]);

    always_comb begin
        stateNext   = state;
        laneCntNext = laneCnt;
        latchMul    = 1'b0;
        loadAlu     = 1'b0;
        loadMul     = 1'b0;
        mulVec      = mulBuf;
        mulVec[laneCnt] = mulLane;

        if (flush) begin
            stateNext   = ST_IDLE;
            laneCntNext = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (valid_in) begin
                        if (op == OP_MUL) begin
                            stateNext   = ST_MUL;
                            laneCntNext = '0;
                            latchMul    = 1'b1;
                        end else begin
                            loadAlu = 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    if (laneCnt == LANE_W'(VEC_SIZE - 1)) begin
                        stateNext   = ST_IDLE;
                        laneCntNext = '0;
                        loadMul     = 1'b1;
                    end else begin
                        laneCntNext = laneCnt + LANE_W'(1);
                    end
                end
                default: stateNext = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_IDLE;
            laneCnt <= '0;
        end else begin
            state   <= stateNext;
            laneCnt <= laneCntNext;
        end
    end

    // Multiply operand latch, lane accumulator and output bank
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mulA        <= '0;
            mulB        <= '0;
            mulImm      <= '0;
            mulCtrl     <= '0;
            mulBuf      <= '0;
            valid_out   <= 1'b0;
            aluResult   <= '0;
            aluOperand1 <= '0;
            aluOperand2 <= '0;
            imm         <= '0;
            wbCtrl      <= '0;
        end else begin
            valid_out <= loadAlu | loadMul;
            if (latchMul) begin
                mulA    <= srcA;
                mulB    <= srcB;
                mulImm  <= imm_in;
                mulCtrl <= ctrlIn;
            end
            if (state == ST_MUL && !flush) begin
                mulBuf <= mulVec;
            end
            if (loadAlu) begin
                aluResult   <= laneOut;
                aluOperand1 <= srcA;
                aluOperand2 <= srcB;
                imm         <= imm_in;
                wbCtrl      <= ctrlIn;
            end else if (loadMul) begin
                aluResult   <= mulVec;
                aluOperand1 <= mulA;
                aluOperand2 <= mulB;
                imm         <= mulImm;
                wbCtrl      <= mulCtrl;
            end
        end
    end

    assign writeEnable  = wbCtrl.writeEnable;
    assign writeMemFrom = wbCtrl.writeMemFrom;
    assign writeRegFrom = wbCtrl.writeRegFrom;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: expectations queued on accept, checked on valid_out.
module tb_execute_stage;

    typedef logic [3:0][15:0] vec_t;

    typedef struct packed {
        vec_t        res;
        vec_t        a;
        vec_t        b;
        logic [15:0] imm;
        logic [3:0]  ctl;
    } exp_t;

    localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND_ = 4'd2, OR_ = 4'd3, XOR_ = 4'd4,
                           SLL = 4'd5, SRL = 4'd6, PASSB = 4'd7, MUL = 4'd8, BAD = 4'hF;

    logic        clk = 1'b0;
    logic        reset;
    logic        validIn, flush, readyOut, validOut;
    logic [3:0]  op;
    vec_t        srcA, srcB, aluResult, aluOperand1, aluOperand2;
    logic [15:0] immIn, imm;
    logic        weIn, wmfIn, weOut, wmfOut;
    logic [1:0]  wrfIn, wrfOut;

    int   vectors = 0;
    int   miscompares = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    execute_stage dut (
        .clk             (clk),
        .reset           (reset),
        .valid_in        (validIn),
        .ready_out       (readyOut),
        .flush           (flush),
        .op              (op),
        .srcA            (srcA),
        .srcB            (srcB),
        .imm_in          (immIn),
        .writeEnable_in  (weIn),
        .writeMemFrom_in (wmfIn),
        .writeRegFrom_in (wrfIn),
        .valid_out       (validOut),
        .aluResult       (aluResult),
        .aluOperand1     (aluOperand1),
        .aluOperand2     (aluOperand2),
        .imm             (imm),
        .writeEnable     (weOut),
        .writeMemFrom    (wmfOut),
        .writeRegFrom    (wrfOut)
    );

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic vec_t mkVec(input logic [15:0] l0, l1, l2, l3);
        vec_t v;
        v[0] = l0; v[1] = l1; v[2] = l2; v[3] = l3;
        return v;
    endfunction

    function automatic vec_t model(input logic [3:0] o, input vec_t a, input vec_t b,
                                   input logic [15:0] iv);
        vec_t        r;
        logic [31:0] p;
        for (int i = 0; i < 4; i++) begin
            p = {16'h0, a[i]} * {16'h0, b[i]};
            case (o)
                ADD:     r[i] = a[i] + b[i];
                SUB:     r[i] = a[i] - b[i];
                AND_:    r[i] = a[i] & b[i];
                OR_:     r[i] = a[i] | b[i];
                XOR_:    r[i] = a[i] ^ b[i];
                SLL:     r[i] = a[i] << iv[3:0];
                SRL:     r[i] = a[i] >> iv[3:0];
                PASSB:   r[i] = b[i];
                MUL:     r[i] = p[15:0];
                default: r[i] = 16'h0;
            endcase
        end
        return r;
    endfunction

    // Present one instruction, hold it until accepted; busy = cycles spent waiting
    task automatic issue(input logic [3:0] o, input vec_t a, input vec_t b, input logic [15:0] iv,
                         input logic [3:0] ctl, input bit expectOut, output int busy);
        exp_t e;
        busy = 0;
        @(negedge clk);
        validIn = 1'b1; op = o; srcA = a; srcB = b; immIn = iv;
        {weIn, wmfIn, wrfIn} = ctl;
        while (readyOut !== 1'b1) begin
            busy++;
            if (busy > 50) begin
                checkVal("accept_timeout", 64'(busy), 64'd0);
                break;
            end
            @(negedge clk);
        end
        if (expectOut) begin
            e.res = model(o, a, b, iv); e.a = a; e.b = b; e.imm = iv; e.ctl = ctl;
            sb.push_back(e);
        end
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        validIn = 1'b0;
    endtask

    // Output monitor
    always @(negedge clk) begin
        if (reset === 1'b1 && validOut === 1'b1) begin
            if (sb.size() == 0) begin
                checkVal("spurious_valid", 64'(validOut), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkVal("aluResult", aluResult, e.res);
                checkVal("aluOperand1", aluOperand1, e.a);
                checkVal("aluOperand2", aluOperand2, e.b);
                checkVal("imm", 64'(imm), 64'(e.imm));
                checkVal("wb_ctrl", 64'({weOut, wmfOut, wrfOut}), 64'(e.ctl));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy;
        vec_t ra, rb;
        reset = 1'b1; validIn = 1'b0; flush = 1'b0; op = '0;
        srcA = '0; srcB = '0; immIn = '0; weIn = 1'b0; wmfIn = 1'b0; wrfIn = '0;

        // Asynchronous reset mid-cycle
        #3 reset = 1'b0;
        #1;
        checkVal("rst_ready", 64'(readyOut), 64'd1);
        checkVal("rst_valid", 64'(validOut), 64'd0);
        checkVal("rst_result", aluResult, 64'd0);
        checkVal("rst_ops", 64'({aluOperand1 | aluOperand2}), 64'd0);
        checkVal("rst_imm_ctl", 64'({imm, weOut, wmfOut, wrfOut}), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        issue(ADD, mkVec(1, 2, 3, 4), mkVec(10, 20, 30, 40), 16'h0, 4'h0, 1'b1, busy);
        idle();
        @(negedge clk);
        checkVal("add_valid_one_cycle", 64'(validOut), 64'd0);

        issue(SUB, mkVec(0, 0, 0, 0), mkVec(1, 1, 1, 1), 16'h0, 4'h0, 1'b1, busy);
        issue(SLL, mkVec(1, 1, 16'h8001, 16'h00F0), mkVec(0, 0, 0, 0), 16'h0013, 4'h0, 1'b1, busy);
        for (int i = 0; i < 8; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            issue(4'(i), ra, rb, 16'($urandom), 4'($urandom), 1'b1, busy);
        end

        // Multiply followed by a held ADD that must wait out the busy cycles
        issue(MUL, mkVec(3, 16'h0100, 16'hFFFF, 7), mkVec(5, 16'h0100, 2, 0), 16'h0005, 4'hA, 1'b1, busy);
        checkVal("mul_accept_busy", 64'(busy), 64'd0);
        issue(ADD, mkVec(5, 6, 7, 8), mkVec(1, 1, 1, 1), 16'h0, 4'h3, 1'b1, busy);
        checkVal("mul_busy_cycles", 64'(busy), 64'd4);
        idle();

        // Flush at lane 2 together with a presented ADD
        issue(MUL, mkVec(2, 3, 4, 5), mkVec(6, 7, 8, 9), 16'h0, 4'h0, 1'b0, busy);
        idle();
        repeat (2) @(negedge clk);
        flush = 1'b1; validIn = 1'b1; op = ADD;
        @(negedge clk);
        flush = 1'b0; validIn = 1'b0;
        checkVal("flush_ready", 64'(readyOut), 64'd1);
        checkVal("flush_valid", 64'(validOut), 64'd0);

        // Full multiply after flush, then passthrough of controls and immediate
        issue(MUL, mkVec(16'h1234, 9, 16'h8000, 16'hFFFF), mkVec(3, 16'hFFFF, 2, 16'hFFFF), 16'h0, 4'h5, 1'b1, busy);
        issue(ADD, mkVec(1, 2, 3, 4), mkVec(5, 6, 7, 8), 16'h0042, 4'b0110, 1'b1, busy);
        checkVal("mul2_busy_cycles", 64'(busy), 64'd4);
        issue(ADD, mkVec(9, 9, 9, 9), mkVec(1, 2, 3, 4), 16'h0042, 4'b1110, 1'b1, busy);
        issue(BAD, mkVec(16'hFFFF, 1, 2, 3), mkVec(4, 5, 6, 7), 16'h0001, 4'h1, 1'b1, busy);
        idle();

        // Reset mid-multiply discards the partial result
        issue(MUL, mkVec(1, 2, 3, 4), mkVec(1, 2, 3, 4), 16'h0, 4'h0, 1'b0, busy);
        idle();
        #2 reset = 1'b0;
        #1;
        checkVal("midmul_rst_ready", 64'(readyOut), 64'd1);
        checkVal("midmul_rst_valid", 64'(validOut), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        issue(XOR_, mkVec(16'hAAAA, 0, 1, 2), mkVec(16'h5555, 3, 3, 3), 16'h0, 4'h0, 1'b1, busy);
        idle();

        repeat (8) @(negedge clk);
        checkVal("sb_drain", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
